// File: rtl/dbus_interconnect_nslave.sv
// dbus_interconnect_nslave
//   Data-bus interconnect between the core LSU and NUM_SLAVES peripheral slaves.
//   Each LSU access is decoded against a base/mask address map. The byte enables
//   and the lane-shifted store data are formed, and one registered request is
//   issued to the selected slave. The block then waits for that slave's ack.
//   Completion is a single lsu_ack_o pulse carrying read data, or an error for
//   an unmapped address, a misaligned/reserved size, or a slave timeout.
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   lsu_req_i/we_i/size_i/addr_i/wdata_i   LSU request (held until lsu_ack_o)
//   lsu_ack_o/err_o/rdata_o                one-cycle completion, error flag, read data
//   peri_req_o/we_o/addr_o/wdata_o/be_o/sel_o   request toward the selected slave
//   peri_ack_i/rdata_i                     per-slave ack pulse and read data
module dbus_interconnect_nslave #(
  parameter int NUM_SLAVES  = 6,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         lsu_req_i,
  input  logic                         lsu_we_i,
  input  logic [1:0]                   lsu_size_i,
  input  logic [ADDR_W-1:0]            lsu_addr_i,
  input  logic [DATA_W-1:0]            lsu_wdata_i,
  output logic                         lsu_ack_o,
  output logic                         lsu_err_o,
  output logic [DATA_W-1:0]            lsu_rdata_o,
  output logic                         peri_req_o,
  output logic                         peri_we_o,
  output logic [ADDR_W-1:0]            peri_addr_o,
  output logic [DATA_W-1:0]            peri_wdata_o,
  output logic [DATA_W/8-1:0]          peri_be_o,
  output logic [NUM_SLAVES-1:0]        peri_sel_o,
  input  logic [NUM_SLAVES-1:0]        peri_ack_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] peri_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic [NUM_SLAVES-1:0] hit_sel_s;
  logic                  hit_s;
  logic                  size_ok_s;
  logic [BE_W-1:0]       be_s;
  logic [DATA_W-1:0]     wdata_s;
  logic [4:0]            shamt_s;
  logic [DATA_W-1:0]     sel_rdata_s;

  // Address decode: one-hot select of the lowest-index matching slave.
  always_comb begin
    hit_sel_s = '0;
    hit_s     = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit_sel_s[i] = ((lsu_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                      (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) & ~hit_s;
      hit_s        = hit_s | hit_sel_s[i];
    end
  end

  // Size/alignment check and byte-lane formation for the current LSU request.
  always_comb begin
    size_ok_s = 1'b0;
    be_s      = '0;
    wdata_s   = '0;
    shamt_s   = {lsu_addr_i[1:0], 3'b000};
    case (lsu_size_i)
      2'b00: begin
        size_ok_s = 1'b1;
        be_s      = 4'b0001 << lsu_addr_i[1:0];
        wdata_s   = {24'h000000, lsu_wdata_i[7:0]} << shamt_s;
      end
      2'b01: begin
        size_ok_s = ~lsu_addr_i[0];
        be_s      = 4'b0011 << lsu_addr_i[1:0];
        wdata_s   = {16'h0000, lsu_wdata_i[15:0]} << shamt_s;
      end
      2'b10: begin
        size_ok_s = (lsu_addr_i[1:0] == 2'b00);
        be_s      = 4'hF;
        wdata_s   = lsu_wdata_i;
      end
      default: begin
        size_ok_s = 1'b0;
        be_s      = '0;
        wdata_s   = '0;
      end
    endcase
    // Loads still carry byte enables but never drive write data.
    if (lsu_we_i) begin
      wdata_s = wdata_s;
    end else begin
      wdata_s = '0;
    end
  end

  // Read-data mux driven by the latched select.
  always_comb begin
    sel_rdata_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_rdata_s = sel_rdata_s | (sel_q[i] ? peri_rdata_i[i*DATA_W +: DATA_W] : '0);
    end
  end

  // Next-state and output-register logic of the IDLE/BUSY/RESP controller.
  // Slave-facing fields hold values only while BUSY, so an idle bus shows zeros.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i && size_ok_s && hit_s) begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = lsu_we_i;
          addr_d  = lsu_addr_i;
          wdata_d = wdata_s;
          be_d    = be_s;
          sel_d   = hit_sel_s;
        end else if (lsu_req_i) begin
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A slave ack in the final counted cycle still wins over the timeout.
        if ((peri_ack_i & sel_q) != '0) begin
          state_d = RESP;
          ack_d   = 1'b1;
          rdata_d = sel_rdata_s;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = RESP;
          cnt_d   = CNT_W'(TIMEOUT_CYC);
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          req_d   = 1'b1;
        end
        if (state_d == RESP) begin
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
          sel_d   = '0;
        end else begin
          sel_d   = sel_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign lsu_ack_o    = ack_q;
  assign lsu_err_o    = err_q;
  assign lsu_rdata_o  = rdata_q;
  assign peri_req_o   = req_q;
  assign peri_we_o    = we_q;
  assign peri_addr_o  = addr_q;
  assign peri_wdata_o = wdata_q;
  assign peri_be_o    = be_q;
  assign peri_sel_o   = sel_q;

endmodule

// File: tb/tb_dbus_interconnect_nslave.sv
// Testbench for dbus_interconnect_nslave: randomized and directed LSU accesses,
// a bench-side slave model, and a scoreboard checked by an independent monitor.
module tb_dbus_interconnect_nslave;

  localparam int NS = 6;
  localparam int TO = 4;
  localparam logic [NS*32-1:0] BASE_P = {32'h5000_0000, 32'h4000_0000, 32'h1000_0000,
                                          32'h2000_0000, 32'h3000_0000, 32'h1000_0000};
  localparam logic [NS*32-1:0] MASK_P = {32'hFF00_0000, 32'hFFFF_0000, 32'hF000_0000,
                                          32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};

  // Address map as seen by the reference model.
  logic [31:0] map_base [NS] = '{32'h1000_0000, 32'h3000_0000, 32'h2000_0000,
                                 32'h1000_0000, 32'h4000_0000, 32'h5000_0000};
  logic [31:0] map_mask [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
                                 32'hF000_0000, 32'hFFFF_0000, 32'hFF00_0000};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lsu_req_i = 1'b0;
  logic              lsu_we_i = 1'b0;
  logic [1:0]        lsu_size_i = 2'b00;
  logic [31:0]       lsu_addr_i = '0;
  logic [31:0]       lsu_wdata_i = '0;
  logic              lsu_ack_o, lsu_err_o;
  logic [31:0]       lsu_rdata_o;
  logic              peri_req_o, peri_we_o;
  logic [31:0]       peri_addr_o, peri_wdata_o;
  logic [3:0]        peri_be_o;
  logic [NS-1:0]     peri_sel_o;
  logic [NS-1:0]     peri_ack_i = '0;
  logic [NS*32-1:0]  peri_rdata_i = '0;

  dbus_interconnect_nslave #(
    .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO),
    .SLAVE_BASE(BASE_P), .SLAVE_MASK(MASK_P)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o),
    .peri_req_o(peri_req_o), .peri_we_o(peri_we_o), .peri_addr_o(peri_addr_o),
    .peri_wdata_o(peri_wdata_o), .peri_be_o(peri_be_o), .peri_sel_o(peri_sel_o),
    .peri_ack_i(peri_ack_i), .peri_rdata_i(peri_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] sel;
    logic [3:0]    be;
    logic [31:0]   addr;
    logic          we;
    logic [31:0]   wdata;
  } peri_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          req_cycles;
    int          start;
  } resp_exp_t;

  peri_exp_t exp_peri_q[$];
  resp_exp_t exp_resp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Slave model configuration written by the driver.
  int          slv_idx = -1;
  int          slv_delay = 0;
  logic [31:0] slv_rdata = '0;
  bit          stray_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference decode: first slave whose masked bits equal the address.
  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (((a ^ map_base[i]) & map_mask[i]) == 32'h0) return i;
    return -1;
  endfunction

  // Slave model: the addressed slave acks on its slv_delay-th request cycle
  // (never when 0); other slaves may emit stray acks and all drive noise data.
  int busy_cnt = 0;
  always @(negedge clk) begin
    logic [NS-1:0] a;
    a = '0;
    for (int j = 0; j < NS; j++) peri_rdata_i[j*32 +: 32] <= $urandom;
    if (slv_idx >= 0) peri_rdata_i[slv_idx*32 +: 32] <= slv_rdata;
    if (peri_req_o) begin
      busy_cnt = busy_cnt + 1;
      if (slv_idx >= 0 && busy_cnt == slv_delay) a[slv_idx] = 1'b1;
      if (stray_en && $urandom_range(0, 1) == 1) begin
        int j;
        j = $urandom_range(0, NS - 1);
        if (j != slv_idx) a[j] = 1'b1;
      end
    end else begin
      busy_cnt = 0;
    end
    peri_ack_i <= a;
  end

  // Monitor: compares slave-side requests and LSU responses with the scoreboard.
  bit prev_req = 1'b0;
  int req_cycles = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req   = 1'b0;
      req_cycles = 0;
    end else begin
      if (peri_req_o && !prev_req) begin
        if (exp_peri_q.size() == 0) begin
          chk("unexpected_peri_req", 32'(peri_req_o), 32'd0);
        end else begin
          peri_exp_t e;
          e = exp_peri_q.pop_front();
          chk("peri_sel", 32'(peri_sel_o), 32'(e.sel));
          chk("peri_be", 32'(peri_be_o), 32'(e.be));
          chk("peri_addr", peri_addr_o, e.addr);
          chk("peri_we", 32'(peri_we_o), 32'(e.we));
          chk("peri_wdata", peri_wdata_o, e.wdata);
        end
      end
      if (peri_req_o) req_cycles = req_cycles + 1;
      prev_req = peri_req_o;
      if (lsu_ack_o) begin
        if (exp_resp_q.size() == 0) begin
          chk("unexpected_lsu_ack", 32'(lsu_ack_o), 32'd0);
        end else begin
          resp_exp_t r;
          r = exp_resp_q.pop_front();
          chk("lsu_err", 32'(lsu_err_o), 32'(r.err));
          chk("lsu_rdata", lsu_rdata_o, r.rdata);
          chk("ack_latency", 32'(cyc - r.start), 32'(r.lat));
          chk("peri_req_cycles", 32'(req_cycles), 32'(r.req_cycles));
          chk("ack_with_req", 32'(peri_req_o), 32'd0);
        end
        req_cycles = 0;
      end
    end
  end

  // Issue one access: compute the expected result, configure the slave, drive it.
  task automatic access(input bit we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                        input bit wait_ack);
    int s, nbytes, off;
    bit legal;
    peri_exp_t pe;
    resp_exp_t re;
    longint unsigned v;
    @(negedge clk);
    s      = ref_slave(addr);
    nbytes = (size == 2'b11) ? 0 : (1 << size);
    off    = int'(addr % 4);
    legal  = (size != 2'b11) && ((addr % nbytes) == 0) && (s >= 0);
    re.start = cyc;
    if (legal) begin
      pe.sel  = '0;
      pe.sel[s] = 1'b1;
      pe.be   = 4'(((1 << nbytes) - 1) << off);
      pe.addr = addr;
      pe.we   = we;
      v = (nbytes == 4) ? longint'(wdata) : (longint'(wdata) % (64'd1 << (8 * nbytes)));
      pe.wdata = we ? 32'(v << (8 * off)) : 32'h0;
      exp_peri_q.push_back(pe);
      if (delay >= 1 && delay <= TO) begin
        re.err = 1'b0; re.rdata = rdata; re.lat = delay + 1; re.req_cycles = delay;
      end else begin
        re.err = 1'b1; re.rdata = 32'h0; re.lat = TO + 1; re.req_cycles = TO;
      end
      slv_idx = s;
    end else begin
      re.err = 1'b1; re.rdata = 32'h0; re.lat = 1; re.req_cycles = 0;
      slv_idx = -1;
    end
    exp_resp_q.push_back(re);
    slv_delay   = delay;
    slv_rdata   = rdata;
    lsu_req_i   = 1'b1;
    lsu_we_i    = we;
    lsu_size_i  = size;
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
    if (wait_ack) begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (lsu_ack_o) break;
      end
      if (k == 20) begin
        chk("ack_wait_timeout", 32'(lsu_ack_o), 32'd1);
        exp_resp_q.delete();
        exp_peri_q.delete();
      end
      lsu_req_i = 1'b0;
      lsu_we_i  = 1'b0;
    end
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_lsu_ack", 32'(lsu_ack_o), 32'd0);
    chk("rst_lsu_err", 32'(lsu_err_o), 32'd0);
    chk("rst_lsu_rdata", lsu_rdata_o, 32'd0);
    chk("rst_peri_req", 32'(peri_req_o), 32'd0);
    chk("rst_peri_sel", 32'(peri_sel_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed scenarios.
    access(1'b1, 2'b10, 32'h2000_0004, 32'hDEAD_BEEF, 3, 32'h0, 1'b1);
    access(1'b0, 2'b00, 32'h2000_0003, 32'h0, 2, 32'h1122_3344, 1'b1);
    access(1'b1, 2'b01, 32'h2000_0001, 32'h0000_ABCD, 1, 32'h0, 1'b1);
    access(1'b1, 2'b00, 32'h7000_0000, 32'h0000_0055, 1, 32'h0, 1'b1);
    access(1'b0, 2'b11, 32'h3000_0000, 32'h0, 1, 32'h0, 1'b1);
    access(1'b0, 2'b10, 32'h2000_0008, 32'h0, 0, 32'h9999_9999, 1'b1);
    access(1'b0, 2'b10, 32'h3000_0010, 32'h0, TO, 32'hCAFE_F00D, 1'b1);
    stray_en = 1'b1;
    access(1'b0, 2'b10, 32'h1000_0010, 32'h0, 3, 32'h0BAD_F00D, 1'b1);
    access(1'b1, 2'b01, 32'h1800_0002, 32'h1234_5678, 2, 32'h0, 1'b1);
    stray_en = 1'b0;

    // Reset while BUSY: outputs clear at once and the access never completes.
    access(1'b1, 2'b10, 32'h5000_0000, 32'h1357_9BDF, 0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_peri_req", 32'(peri_req_o), 32'd0);
    chk("abort_peri_sel", 32'(peri_sel_o), 32'd0);
    chk("abort_peri_addr", peri_addr_o, 32'd0);
    chk("abort_peri_wdata", peri_wdata_o, 32'd0);
    chk("abort_lsu_ack", 32'(lsu_ack_o), 32'd0);
    exp_resp_q.delete();
    lsu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_abort_no_ack", 32'(lsu_ack_o), 32'd0);
    access(1'b0, 2'b00, 32'h5000_0001, 32'h0, 1, 32'hA5A5_5A5A, 1'b1);

    // Randomized traffic across mapped, overlapping and unmapped regions.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [31:0] hi;
      case ($urandom_range(0, 7))
        0: hi = 32'h1000_0000;
        1: hi = 32'h1800_0000;
        2: hi = 32'h2000_0000;
        3: hi = 32'h3000_0000;
        4: hi = 32'h4000_0000;
        5: hi = 32'h4100_0000;
        6: hi = 32'h5000_0000;
        default: hi = 32'h7000_0000;
      endcase
      a = hi | ($urandom & 32'h0000_FFFF);
      stray_en = 1'($urandom_range(0, 1));
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
             $urandom_range(0, TO), $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 32'(exp_resp_q.size()), 32'd0);
    chk("peri_queue_drained", 32'(exp_peri_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
